// File: rtl/apb_read_burst_master.sv
// APB read burst master: walks one AXI read burst descriptor as a series of
// APB reads and queues each prdata/response pair in a first-word-fall-through FIFO.
module apb_read_burst_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic [3:0]                    len,
    input  logic [2:0]                    size,
    input  logic [1:0]                    burst,
    output logic                          busy,
    output logic                          done,
    output logic                          slverr,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          pready,
    input  logic                          pslverr,
    input  logic                          fifo_read,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [1:0]                    fifo_resp,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: an APB transfer is one SETUP cycle then ACCESS cycles until
    // pready=1; the FIFO pops on fifo_read only while it is not empty.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_STALL  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_len;
    logic [3:0]            r_beat;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_done;
    logic                  r_slverr;

    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [1:0]            r_mem_resp [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_last;
    logic                  w_room_now;
    logic                  w_room_after;
    logic                  w_wrap_ok;
    logic [CNT_W-1:0]      w_count_after;
    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_wrap_mask;
    logic [ADDR_WIDTH-1:0] w_addr_incr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;

    assign w_push        = (r_state == S_ACCESS) && pready;
    assign w_pop         = fifo_read && (r_count != '0);
    assign w_last        = (r_beat == r_len);
    assign w_count_after = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_room_now    = (r_count < CNT_W'(FIFO_DEPTH));
    // Room is judged on the post-push occupancy so a stalled slot is never overbooked.
    assign w_room_after  = (w_count_after < CNT_W'(FIFO_DEPTH));

    assign w_step      = ADDR_WIDTH'(1) << r_size;
    assign w_wrap_mask = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);
    assign w_addr_incr = r_addr + w_step;
    assign w_wrap_ok   = (r_len == 4'd1) || (r_len == 4'd3) || (r_len == 4'd7) || (r_len == 4'd15);

    always_comb begin
        w_addr_nxt = w_addr_incr;
        case (r_burst)
            2'b00:   w_addr_nxt = r_addr;
            2'b10:   w_addr_nxt = w_wrap_ok ? ((r_addr & ~w_wrap_mask) | (w_addr_incr & w_wrap_mask))
                                            : w_addr_incr;
            default: w_addr_nxt = w_addr_incr;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = w_room_now ? S_SETUP : S_STALL;
            S_STALL:  if (w_room_now) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (pready) begin
                    if (w_last) w_state_nxt = S_IDLE;
                    else        w_state_nxt = w_room_after ? S_SETUP : S_STALL;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        psel    = (r_state == S_SETUP) || (r_state == S_ACCESS);
        penable = (r_state == S_ACCESS);
        paddr   = r_addr;
        pwrite  = 1'b0;
        busy    = (r_state != S_IDLE);
        done    = r_done;
        slverr  = r_slverr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_done   <= 1'b0;
            r_slverr <= 1'b0;
        end else begin
            r_done <= w_push && w_last;
            if ((r_state == S_IDLE) && start) begin
                r_addr   <= addr;
                r_len    <= len;
                r_size   <= size;
                r_burst  <= burst;
                r_beat   <= '0;
                r_slverr <= 1'b0;
            end else if (w_push) begin
                r_slverr <= r_slverr | pslverr;
                if (!w_last) begin
                    r_beat <= r_beat + 4'd1;
                    r_addr <= w_addr_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= prdata;
            r_mem_resp[r_wr_ptr] <= pslverr ? 2'b10 : 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_after;
        end
    end

    assign fifo_empty = (r_count == '0);
    assign fifo_count = r_count;
    assign fifo_data  = fifo_empty ? '0 : r_mem_data[r_rd_ptr];
    assign fifo_resp  = fifo_empty ? 2'b00 : r_mem_resp[r_rd_ptr];

endmodule

// File: doc/apb_read_burst_master.md
Name: apb_read_burst_master

Overview:
- Upstream feeder for the AXI read-data return stage of the AXI2APB bridge.
- Takes one latched AXI read burst descriptor from the bridge engine and issues one APB read transfer per beat.
- Pushes each prdata/response pair into an internal FWFT FIFO. The downstream AXI R-channel stage pops that FIFO with a one-cycle read strobe.

Parameters:
- ADDR_WIDTH, 32, APB/AXI address width.
- DATA_WIDTH, 32, APB data width and FIFO entry data width.
- FIFO_DEPTH, 4, read-data FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin burst; sampled only in IDLE
- addr  in  ADDR_WIDTH  burst start address
- len  in  4  beats minus 1 (0..15)
- size  in  3  bytes per beat = 1<<size
- burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse, last beat pushed
- slverr  out  1  sticky: any beat of the current or last burst got pslverr
- paddr  out  ADDR_WIDTH  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  tied 0
- prdata  in  DATA_WIDTH  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error
- fifo_read  in  1  pop head entry
- fifo_data  out  DATA_WIDTH  head data (FWFT)
- fifo_resp  out  2  head response: 00 OKAY, 10 SLVERR
- fifo_empty  out  1  FIFO empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Reset values: busy=0, done=0, slverr=0, psel=0, penable=0, paddr=0, pwrite=0, fifo_empty=1, fifo_count=0, fifo_data=0, fifo_resp=0.
- FSM states: IDLE, SETUP, ACCESS, STALL.
- IDLE:
  - On start=1, latch addr/len/size/burst, clear beat counter and slverr.
  - Go to SETUP if fifo_count < FIFO_DEPTH, else go to STALL.
  - start outside IDLE is ignored.
- STALL: psel=0. Move to SETUP on the first cycle where fifo_count < FIFO_DEPTH.
- SETUP: psel=1, penable=0, paddr=current beat address. Always moves to ACCESS next cycle.
- ACCESS: psel=1, penable=1, paddr held.
  - On pready=1: push {prdata, pslverr?10:00} into the FIFO. slverr |= pslverr.
  - If beat==len: go to IDLE, pulse done next cycle.
  - Otherwise: beat+1, advance address, go to SETUP if a slot is free, else STALL.
  - pready=0 holds ACCESS indefinitely.
- Slot reservation: a transfer is only started (SETUP) when a free slot exists. Only one transfer is outstanding, so a push never overflows.
- Address generation, with B = 1<<size:
  - FIXED: address unchanged.
  - INCR: addr+B, modulo 2^ADDR_WIDTH.
  - WRAP: wrap boundary W=(len+1)*B. next = (addr & ~(W-1)) | ((addr+B) & (W-1)).
  - WRAP with len not in {1,3,7,15} behaves as INCR.
- busy=1 from the cycle after start is accepted until the cycle done is asserted; busy=0 in that done cycle.
- Latency, zero-wait:
  - start accepted at edge 0 -> SETUP at cycle 1, ACCESS at cycle 2.
  - First push at edge 3; fifo_empty=0 from cycle 3.
  - Each beat costs 2 cycles. A 16-beat burst completes in 32 cycles.
- FIFO:
  - First-word fall-through. fifo_data/fifo_resp show the head whenever not empty.
  - fifo_read while empty is ignored (no underflow, count stays 0).
  - Simultaneous push and pop: count unchanged, data order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - FIFO contents survive across bursts. A new burst may start while old entries are still unread.
- pslverr does not abort the burst: all len+1 beats are always issued.
- Reset mid-burst: asynchronously, psel/penable drop and the FIFO empties; all state returns to reset values.

Test Plan:
- Zero-wait INCR: addr=0x100, len=3, size=2, downstream pops every cycle -> paddr sequence 0x100, 0x104, 0x108, 0x10C; 4 entries popped in order; done pulses at cycle 9 after start; slverr=0.
- WRAP: addr=0x38, len=3, size=2 -> paddr 0x38, 0x3C, 0x30, 0x34. FIXED: addr=0x20, len=2 -> 0x20 three times.
- Backpressure: FIFO_DEPTH=4, len=7, no pops -> after 4 beats psel stays 0 (STALL) with fifo_count=4; popping one entry -> exactly one more SETUP/ACCESS; all 8 entries eventually read in order.
- Wait states + error: pready low 3 cycles on beat 1, pslverr=1 on beat 2 of len=3 -> ACCESS held 3 extra cycles with paddr stable; entry 2 has fifo_resp=10; slverr=1 after done; all 4 beats still issued.
- Boundaries: start while busy is ignored; fifo_read while empty leaves fifo_count=0; simultaneous push and pop at count=2 keeps count=2; start in IDLE with FIFO full -> goes to STALL, no psel.
- Reset: deassert rst_n during ACCESS of beat 2 -> psel=0, penable=0, fifo_empty=1, busy=0 immediately; a new start after release runs normally from beat 0.
